// File: rtl/pc_gen.sv
// pc_gen: fetch-address generator.
// Produces the registered fetch PC, applies branch/trap redirects with
// trap priority, and holds a redirect that arrives while fetch is stalled.
// After each applied redirect, fetch_kill squashes the next KILL_CYCLES fetches.
// It also flags branch targets that are not word-aligned.
module pc_gen #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int          KILL_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_stall,
    input  logic        br_taken,
    input  logic [31:0] br_target,
    input  logic        trap_req,
    input  logic [31:0] trap_vec,
    output logic [31:0] pc,
    output logic        fetch_kill,
    output logic        misalign_err,
    output logic [31:0] misalign_addr
);

    typedef enum logic {
        RUN       = 1'b0,
        HOLD_PEND = 1'b1
    } state_t;

    // Kill-count reload value, narrowed once to the counter width.
    localparam logic [1:0] KILL_LD = 2'(KILL_CYCLES);

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        pend_trap_q, pend_trap_d;
    logic [31:0] pend_target_q, pend_target_d;
    logic [1:0]  kcnt_q, kcnt_d;
    logic        merr_q, merr_d;
    logic [31:0] maddr_q, maddr_d;

    // Redirect selected for this cycle (trap beats branch).
    logic        new_req;
    logic [31:0] new_target;
    // Redirect actually loaded into pc on this edge.
    logic        apply;
    logic        apply_trap;
    logic [31:0] apply_target;

    assign new_req    = trap_req | br_taken;
    assign new_target = trap_req ? trap_vec : br_target;

    // Next-state logic: sequencing, pending capture, pc/kill/misalign update.
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        pend_trap_d   = pend_trap_q;
        pend_target_d = pend_target_q;
        kcnt_d        = kcnt_q;
        merr_d        = 1'b0;
        maddr_d       = maddr_q;
        apply         = 1'b0;
        apply_trap    = 1'b0;
        apply_target  = 32'h0;

        case (state_q)
            RUN: begin
                if (if_stall) begin
                    // Fetch is frozen: park the redirect until the stall lifts.
                    if (new_req) begin
                        pend_trap_d   = trap_req;
                        pend_target_d = new_target;
                        state_d       = HOLD_PEND;
                    end
                end else if (new_req) begin
                    apply        = 1'b1;
                    apply_trap   = trap_req;
                    apply_target = new_target;
                end else begin
                    pc_d = pc_q + 32'd4;
                end
            end
            HOLD_PEND: begin
                if (if_stall) begin
                    // A trap always replaces the parked entry; a branch only
                    // replaces a parked branch.
                    if (trap_req) begin
                        pend_trap_d   = 1'b1;
                        pend_target_d = trap_vec;
                    end else if (br_taken && !pend_trap_q) begin
                        pend_trap_d   = 1'b0;
                        pend_target_d = br_target;
                    end
                end else begin
                    // Stall released: apply the parked redirect unless a fresh
                    // one of equal or higher priority arrives in this cycle.
                    state_d = RUN;
                    apply   = 1'b1;
                    if (new_req && (trap_req || !pend_trap_q)) begin
                        apply_trap   = trap_req;
                        apply_target = new_target;
                    end else begin
                        apply_trap   = pend_trap_q;
                        apply_target = pend_target_q;
                    end
                end
            end
            default: state_d = RUN;
        endcase

        if (apply) begin
            pc_d   = {apply_target[31:2], 2'b00};
            kcnt_d = KILL_LD;
            // Trap vectors are aligned silently; only branches are reported.
            if (!apply_trap && (apply_target[1:0] != 2'b00)) begin
                merr_d  = 1'b1;
                maddr_d = apply_target;
            end
        end else if (!if_stall && (kcnt_q != 2'd0)) begin
            kcnt_d = kcnt_q - 2'd1;
        end
    end

    // State register with synchronous reset that overrides everything else.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= RUN;
            pc_q          <= RESET_PC;
            pend_trap_q   <= 1'b0;
            pend_target_q <= 32'h0;
            kcnt_q        <= 2'd0;
            merr_q        <= 1'b0;
            maddr_q       <= 32'h0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            pend_trap_q   <= pend_trap_d;
            pend_target_q <= pend_target_d;
            kcnt_q        <= kcnt_d;
            merr_q        <= merr_d;
            maddr_q       <= maddr_d;
        end
    end

    assign pc            = pc_q;
    assign fetch_kill    = (kcnt_q != 2'd0);
    assign misalign_err  = merr_q;
    assign misalign_addr = maddr_q;

endmodule

// File: tb/tb_pc_gen.sv
// tb_pc_gen: directed-vector bench for pc_gen with a queue-based scoreboard.
// The stimulus drives inputs on the falling edge and queues the hand-computed
// values expected after the next rising edge. An independent monitor pops the
// queue and compares shortly after each rising edge.
module tb_pc_gen;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_stall;
    logic        br_taken;
    logic [31:0] br_target;
    logic        trap_req;
    logic [31:0] trap_vec;
    logic [31:0] pc;
    logic        fetch_kill;
    logic        misalign_err;
    logic [31:0] misalign_addr;

    int checks   = 0;
    int failures = 0;
    int step_no  = 0;

    typedef struct {
        int          id;
        logic [31:0] pc;
        logic        kill;
        logic        merr;
        logic [31:0] maddr;
    } exp_t;

    exp_t exp_q[$];

    pc_gen #(
        .RESET_PC    (32'h0000_0000),
        .KILL_CYCLES (2)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .if_stall      (if_stall),
        .br_taken      (br_taken),
        .br_target     (br_target),
        .trap_req      (trap_req),
        .trap_vec      (trap_vec),
        .pc            (pc),
        .fetch_kill    (fetch_kill),
        .misalign_err  (misalign_err),
        .misalign_addr (misalign_addr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int id, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s step=%0d got=%h want=%h", nm, id, act, req);
        end
    endtask

    // One transaction: drive inputs for a cycle and queue the expected result.
    task automatic step(input logic r, input logic s,
                        input logic b, input logic [31:0] bt,
                        input logic t, input logic [31:0] tv,
                        input logic [31:0] epc, input logic ek,
                        input logic em, input logic [31:0] ema);
        exp_t e;
        @(negedge clk);
        rst       = r;
        if_stall  = s;
        br_taken  = b;
        br_target = bt;
        trap_req  = t;
        trap_vec  = tv;
        step_no++;
        e.id    = step_no;
        e.pc    = epc;
        e.kill  = ek;
        e.merr  = em;
        e.maddr = ema;
        exp_q.push_back(e);
    endtask

    // Monitor: compare each presented output against the oldest expectation.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("pc",            e.id, pc,                    e.pc);
                chk("fetch_kill",    e.id, {31'b0, fetch_kill},   {31'b0, e.kill});
                chk("misalign_err",  e.id, {31'b0, misalign_err}, {31'b0, e.merr});
                chk("misalign_addr", e.id, misalign_addr,         e.maddr);
                $display("step %0d rst=%b stall=%b br=%b bt=%h trap=%b tv=%h -> pc=%h kill=%b merr=%b maddr=%h",
                         e.id, rst, if_stall, br_taken, br_target, trap_req, trap_vec,
                         pc, fetch_kill, misalign_err, misalign_addr);
            end
        end
    end

    initial begin
        int budget;
        rst = 1'b1; if_stall = 1'b0; br_taken = 1'b0; br_target = 32'h0;
        trap_req = 1'b0; trap_vec = 32'h0;

        //   rst  stl  br   bt            trap tv            pc            kill merr maddr
        // Sequential run after reset.
        step(1, 0, 0, 32'h0,        0, 32'h0,   32'h0,        0, 0, 32'h0);
        step(0, 0, 0, 32'h0,        0, 32'h0,   32'h4,        0, 0, 32'h0);
        step(0, 0, 0, 32'h0,        0, 32'h0,   32'h8,        0, 0, 32'h0);
        step(0, 0, 0, 32'h0,        0, 32'h0,   32'hC,        0, 0, 32'h0);
        step(0, 0, 0, 32'h0,        0, 32'h0,   32'h10,       0, 0, 32'h0);
        step(0, 0, 0, 32'h0,        0, 32'h0,   32'h14,       0, 0, 32'h0);
        // Reset again, reach pc=8, branch to 0x100.
        step(1, 0, 0, 32'h0,        0, 32'h0,   32'h0,        0, 0, 32'h0);
        step(0, 0, 0, 32'h0,        0, 32'h0,   32'h4,        0, 0, 32'h0);
        step(0, 0, 0, 32'h0,        0, 32'h0,   32'h8,        0, 0, 32'h0);
        step(0, 0, 1, 32'h100,      0, 32'h0,   32'h100,      1, 0, 32'h0);
        step(0, 0, 0, 32'h0,        0, 32'h0,   32'h104,      1, 0, 32'h0);
        step(0, 0, 0, 32'h0,        0, 32'h0,   32'h108,      0, 0, 32'h0);
        step(0, 0, 0, 32'h0,        0, 32'h0,   32'h10C,      0, 0, 32'h0);
        // Trap beats branch in the same cycle.
        step(0, 0, 1, 32'h200,      1, 32'h80,  32'h80,       1, 0, 32'h0);
        step(0, 0, 0, 32'h0,        0, 32'h0,   32'h84,       1, 0, 32'h0);
        step(0, 0, 0, 32'h0,        0, 32'h0,   32'h88,       0, 0, 32'h0);
        // Misaligned trap and misaligned ignored branch: no error.
        step(0, 0, 1, 32'h201,      1, 32'h83,  32'h80,       1, 0, 32'h0);
        // Redirect while kill active reloads the count.
        step(0, 0, 1, 32'h400,      0, 32'h0,   32'h400,      1, 0, 32'h0);
        step(0, 0, 0, 32'h0,        0, 32'h0,   32'h404,      1, 0, 32'h0);
        step(0, 0, 0, 32'h0,        0, 32'h0,   32'h408,      0, 0, 32'h0);
        // Stalled: branch, trap, branch -> trap survives.
        step(0, 1, 1, 32'h40,       0, 32'h0,   32'h408,      0, 0, 32'h0);
        step(0, 1, 0, 32'h0,        1, 32'h300, 32'h408,      0, 0, 32'h0);
        step(0, 1, 1, 32'h50,       0, 32'h0,   32'h408,      0, 0, 32'h0);
        step(0, 0, 0, 32'h0,        0, 32'h0,   32'h300,      1, 0, 32'h0);
        step(0, 0, 0, 32'h0,        0, 32'h0,   32'h304,      1, 0, 32'h0);
        step(0, 0, 0, 32'h0,        0, 32'h0,   32'h308,      0, 0, 32'h0);
        // Stall freezes the kill counter.
        step(0, 0, 1, 32'h500,      0, 32'h0,   32'h500,      1, 0, 32'h0);
        step(0, 1, 0, 32'h0,        0, 32'h0,   32'h500,      1, 0, 32'h0);
        step(0, 1, 0, 32'h0,        0, 32'h0,   32'h500,      1, 0, 32'h0);
        step(0, 0, 0, 32'h0,        0, 32'h0,   32'h504,      1, 0, 32'h0);
        step(0, 0, 0, 32'h0,        0, 32'h0,   32'h508,      0, 0, 32'h0);
        // Pending branch loses to a trap arriving at release.
        step(0, 1, 1, 32'h600,      0, 32'h0,   32'h508,      0, 0, 32'h0);
        step(0, 0, 0, 32'h0,        1, 32'h700, 32'h700,      1, 0, 32'h0);
        // Pending trap beats a branch arriving at release.
        step(0, 1, 0, 32'h0,        1, 32'h800, 32'h700,      1, 0, 32'h0);
        step(0, 0, 1, 32'h900,      0, 32'h0,   32'h800,      1, 0, 32'h0);
        step(0, 0, 0, 32'h0,        0, 32'h0,   32'h804,      1, 0, 32'h0);
        step(0, 0, 0, 32'h0,        0, 32'h0,   32'h808,      0, 0, 32'h0);
        // Pending branch overwritten by a later branch.
        step(0, 1, 1, 32'hA00,      0, 32'h0,   32'h808,      0, 0, 32'h0);
        step(0, 1, 1, 32'hB00,      0, 32'h0,   32'h808,      0, 0, 32'h0);
        step(0, 0, 0, 32'h0,        0, 32'h0,   32'hB00,      1, 0, 32'h0);
        step(0, 0, 0, 32'h0,        0, 32'h0,   32'hB04,      1, 0, 32'h0);
        step(0, 0, 0, 32'h0,        0, 32'h0,   32'hB08,      0, 0, 32'h0);
        // Misaligned branch target.
        step(0, 0, 1, 32'h106,      0, 32'h0,   32'h104,      1, 1, 32'h106);
        step(0, 0, 0, 32'h0,        0, 32'h0,   32'h108,      1, 0, 32'h106);
        step(0, 0, 0, 32'h0,        0, 32'h0,   32'h10C,      0, 0, 32'h106);
        // Misaligned pending branch reports at apply, not at latch.
        step(0, 1, 1, 32'h207,      0, 32'h0,   32'h10C,      0, 0, 32'h106);
        step(0, 0, 0, 32'h0,        0, 32'h0,   32'h204,      1, 1, 32'h207);
        step(0, 0, 0, 32'h0,        0, 32'h0,   32'h208,      1, 0, 32'h207);
        step(0, 0, 0, 32'h0,        1, 32'h33,  32'h30,       1, 0, 32'h207);
        // Wrap-around.
        step(0, 0, 1, 32'hFFFFFFF8, 0, 32'h0,   32'hFFFFFFF8, 1, 0, 32'h207);
        step(0, 0, 0, 32'h0,        0, 32'h0,   32'hFFFFFFFC, 1, 0, 32'h207);
        step(0, 0, 0, 32'h0,        0, 32'h0,   32'h0,        0, 0, 32'h207);
        step(0, 0, 0, 32'h0,        0, 32'h0,   32'h4,        0, 0, 32'h207);
        // Reset during a pending stalled redirect and active kill.
        step(0, 0, 1, 32'h900,      0, 32'h0,   32'h900,      1, 0, 32'h207);
        step(0, 1, 1, 32'hC00,      0, 32'h0,   32'h900,      1, 0, 32'h207);
        step(1, 1, 0, 32'h0,        1, 32'hD00, 32'h0,        0, 0, 32'h0);
        step(0, 0, 0, 32'h0,        0, 32'h0,   32'h4,        0, 0, 32'h0);
        step(0, 0, 0, 32'h0,        0, 32'h0,   32'h8,        0, 0, 32'h0);
        // Reset overrides a misaligned branch.
        step(1, 0, 1, 32'h103,      0, 32'h0,   32'h0,        0, 0, 32'h0);
        step(0, 0, 0, 32'h0,        0, 32'h0,   32'h4,        0, 0, 32'h0);

        @(negedge clk);
        rst = 1'b0; if_stall = 1'b0; br_taken = 1'b0; trap_req = 1'b0;

        // Bounded drain of the scoreboard.
        budget = 0;
        while (exp_q.size() > 0 && budget < 10) begin
            @(negedge clk);
            budget++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain pending=%0d want=0", exp_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
